// File: rtl/silife_max7219.sv
// silife_max7219: serialises life-matrix rows as SPI frames to a daisy-chain of MAX7219 drivers
// Ports:
//   clk, reset        system clock, asynchronous active-high reset
//   enable            1 = send driver init once, then refresh all rows continuously
//   brightness        MAX7219 intensity, resent at a frame start whenever it changes
//   cells             matrix row addressed by row_select (combinational read)
//   row_select        registered row index to the matrix read port
//   spi_sck/mosi      SPI mode 0, MSB first; spi_cs_n drives MAX7219 LOAD
//   busy              high whenever the sequencer is not idle
//   frame_done        one-cycle pulse after the last row of a frame
module silife_max7219 #(
    parameter int WIDTH   = 8,
    parameter int HEIGHT  = 8,
    parameter int CLK_DIV = 4
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic                                        enable,
    input  logic [3:0]                                  brightness,
    input  logic [WIDTH-1:0]                            cells,
    output logic [(HEIGHT > 1 ? $clog2(HEIGHT) : 1)-1:0] row_select,
    output logic                                        spi_sck,
    output logic                                        spi_mosi,
    output logic                                        spi_cs_n,
    output logic                                        busy,
    output logic                                        frame_done
);
    localparam int RW     = HEIGHT > 1 ? $clog2(HEIGHT) : 1;
    localparam int NCHIPS = WIDTH / 8;
    localparam int B      = 16 * NCHIPS;
    localparam int BW     = $clog2(B);
    localparam int CW     = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;

    typedef enum logic [2:0] {S_IDLE, S_FSTART, S_SELECT, S_LOAD, S_SHIFT, S_TAIL, S_GAP, S_DONE} state_t;
    // What the current transfer carries: one of the five init words, a brightness update, or a row
    typedef enum logic [1:0] {K_INIT, K_BRIGHT, K_ROW} kind_t;

    state_t          state, state_n;
    kind_t           kind;
    logic [2:0]      idx;
    logic [RW-1:0]   row;
    logic [B-1:0]    sr, word;
    logic [BW-1:0]   bitc;
    logic [CW-1:0]   cnt;
    logic            hi, init_done, tick, last_row;
    logic [3:0]      last_br, cfg_addr;
    logic [2:0]      cfg_sel;
    logic [7:0]      cfg_data;

    assign tick       = cnt == CW'(CLK_DIV - 1);
    assign last_row   = kind == K_ROW && row == RW'(HEIGHT - 1);
    assign spi_sck    = state == S_SHIFT && hi;
    assign spi_cs_n   = !(state == S_SHIFT || state == S_TAIL);
    assign spi_mosi   = sr[B-1];
    assign busy       = state != S_IDLE;
    assign frame_done = state == S_DONE;

    // Transfer word; chip NCHIPS-1 sits in the top 16 bits so it is shifted out first
    always_comb begin
        cfg_sel  = kind == K_BRIGHT ? 3'd2 : idx;
        cfg_addr = cfg_sel == 3'd0 ? 4'h9 : cfg_sel == 3'd1 ? 4'hB : cfg_sel == 3'd2 ? 4'hA : cfg_sel == 3'd3 ? 4'hF : 4'hC;
        cfg_data = cfg_sel == 3'd1 ? 8'(HEIGHT - 1) : cfg_sel == 3'd2 ? {4'h0, brightness} : cfg_sel == 3'd4 ? 8'h01 : 8'h00;
        word     = '0;
        for (int k = 0; k < NCHIPS; k++)
            word[16*k +: 16] = kind == K_ROW ? {4'h0, 4'(row_select) + 4'd1, cells[8*k +: 8]} : {4'h0, cfg_addr, cfg_data};
    end

    // Enable is honoured only between transfers, so a started word always completes with its gap
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:   if (enable) state_n = init_done ? S_FSTART : S_LOAD;
            S_FSTART: state_n = !enable ? S_IDLE : brightness != last_br ? S_LOAD : S_SELECT;
            S_SELECT: state_n = enable ? S_LOAD : S_IDLE;
            S_LOAD:   state_n = enable ? S_SHIFT : S_IDLE;
            S_SHIFT:  if (tick && hi && bitc == BW'(B - 1)) state_n = S_TAIL;
            S_TAIL:   if (tick) state_n = S_GAP;
            S_GAP:    if (tick) state_n = last_row ? S_DONE : !enable ? S_IDLE : kind != K_INIT ? S_SELECT : idx == 3'd4 ? S_FSTART : S_LOAD;
            S_DONE:   state_n = enable ? S_FSTART : S_IDLE;
            default:  state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            kind       <= K_INIT;
            idx        <= '0;
            row        <= '0;
            row_select <= '0;
            sr         <= '0;
            bitc       <= '0;
            cnt        <= '0;
            hi         <= 1'b0;
            init_done  <= 1'b0;
            last_br    <= '0;
        end else begin
            state <= state_n;
            // cnt times one SCK half-period; restarts on every phase or state change
            cnt <= (tick || state_n != state) ? '0 : cnt + 1'b1;
            if (state == S_IDLE && state_n == S_LOAD) begin
                kind <= K_INIT;
                idx  <= '0;
            end
            if (state == S_FSTART) begin
                row  <= '0;
                kind <= K_BRIGHT;
            end
            if (state == S_SELECT) begin
                row_select <= row;
                kind       <= K_ROW;
            end
            if (state == S_LOAD && state_n == S_SHIFT) begin
                sr   <= word;
                bitc <= '0;
                hi   <= 1'b0;
                if (kind == K_BRIGHT || (kind == K_INIT && idx == 3'd2)) last_br <= brightness;
            end
            // Data advances on the falling SCK edge so it is stable around the next rising edge
            if (state == S_SHIFT && tick) begin
                hi <= !hi;
                if (hi) begin
                    sr   <= sr << 1;
                    bitc <= bitc + 1'b1;
                end
            end
            if (state == S_GAP && state_n == S_LOAD) idx <= idx + 3'd1;
            if (state == S_GAP && state_n == S_SELECT && kind == K_ROW) row <= row + 1'b1;
            if (state == S_GAP && tick && kind == K_INIT && idx == 3'd4) init_done <= 1'b1;
        end
    end
endmodule

// File: tb/tb_silife_max7219.sv
// tb_silife_max7219: randomized scoreboard bench decoding the SPI stream back into words
module tb_silife_max7219;
    localparam int WIDTH   = 16;
    localparam int HEIGHT  = 8;
    localparam int CLK_DIV = 2;
    localparam int B       = 2 * WIDTH;
    localparam int RW      = $clog2(HEIGHT);
    localparam int LIMIT   = 5000;

    logic              clk = 1'b0;
    logic              reset, enable;
    logic [3:0]        brightness;
    logic [WIDTH-1:0]  cells;
    logic [RW-1:0]     row_select;
    logic              spi_sck, spi_mosi, spi_cs_n, busy, frame_done;
    logic [WIDTH-1:0]  matrix [HEIGHT];

    assign cells = matrix[row_select];

    silife_max7219 #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .CLK_DIV(CLK_DIV)) dut (
        .clk(clk), .reset(reset), .enable(enable), .brightness(brightness), .cells(cells),
        .row_select(row_select), .spi_sck(spi_sck), .spi_mosi(spi_mosi), .spi_cs_n(spi_cs_n),
        .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [B-1:0] w;
        int           rs;
    } exp_t;

    exp_t       exp_q[$];
    int         checks = 0;
    int         failures = 0;
    logic [3:0] model_br;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Reference words: chips listed in transmission order, the highest chip first
    function automatic logic [B-1:0] cfg_word(input logic [3:0] a, input logic [7:0] d);
        logic [B-1:0] w = '0;
        for (int c = WIDTH/8 - 1; c >= 0; c--) w = (w << 16) | B'({4'h0, a, d});
        return w;
    endfunction

    function automatic logic [B-1:0] row_word(input int r, input logic [WIDTH-1:0] v);
        logic [B-1:0] w = '0;
        for (int c = WIDTH/8 - 1; c >= 0; c--) w = (w << 16) | B'({4'h0, 4'(r + 1), v[8*c +: 8]});
        return w;
    endfunction

    task automatic push(input logic [B-1:0] w, input int rs);
        exp_t e;
        e.w  = w;
        e.rs = rs;
        exp_q.push_back(e);
    endtask

    task automatic push_init();
        push(cfg_word(4'h9, 8'h00), -1);
        push(cfg_word(4'hB, 8'(HEIGHT - 1)), -1);
        push(cfg_word(4'hA, {4'h0, brightness}), -1);
        push(cfg_word(4'hF, 8'h00), -1);
        push(cfg_word(4'hC, 8'h01), -1);
        model_br = brightness;
    endtask

    // Monitor: rebuilds each cs_n window from sck rising edges and scores it
    logic         in_win = 1'b0, prev_sck = 1'b0, prev_mosi = 1'b0, prev_fd = 1'b0;
    int           nbits, wlen, mosi_bad, busy_bad, rs_at, last_rs = -1;
    logic [B-1:0] data;
    exp_t         got;

    always @(negedge clk) begin
        if (reset) begin
            in_win = 1'b0;
            prev_sck = 1'b0;
            prev_fd = 1'b0;
        end else begin
            if (!spi_cs_n && !in_win) begin
                in_win = 1'b1;
                nbits = 0;
                wlen = 0;
                data = '0;
                mosi_bad = 0;
                busy_bad = 0;
                rs_at = int'(row_select);
            end
            if (in_win && !spi_cs_n) begin
                wlen++;
                if (spi_sck && !prev_sck) begin
                    data = {data[B-2:0], spi_mosi};
                    nbits++;
                end
                if (wlen > 1 && spi_mosi !== prev_mosi && !(prev_sck && !spi_sck)) mosi_bad++;
                if (!busy) busy_bad++;
            end else if (in_win) begin
                in_win = 1'b0;
                check("window_bits", nbits, B);
                check("window_length", wlen, (2 * B + 1) * CLK_DIV);
                check("mosi_only_on_sck_fall", mosi_bad, 0);
                check("busy_in_window", busy_bad, 0);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_window: got %0h, expected no transfer", data);
                end else begin
                    got = exp_q.pop_front();
                    check("word", data, got.w);
                    if (got.rs >= 0) check("row_select_in_window", rs_at, got.rs);
                    last_rs = got.rs >= 0 ? rs_at : -1;
                end
            end
            if (frame_done) begin
                check("frame_done_after_last_row", last_rs, HEIGHT - 1);
                check("frame_done_one_cycle", prev_fd, 0);
            end
            prev_sck = spi_sck;
            prev_mosi = spi_mosi;
            prev_fd = frame_done;
        end
    end

    task automatic wait_win(input int r);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(!spi_cs_n && row_select == RW'(r)) && n < LIMIT);
        check($sformatf("wait_row%0d_window", r), n < LIMIT, 1);
    endtask

    task automatic wait_frame_done();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_done && n < LIMIT);
        check("wait_frame_done", n < LIMIT, 1);
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < LIMIT);
        check("wait_busy_low", n < LIMIT, 1);
    endtask

    task automatic randomize_matrix();
        for (int r = 0; r < HEIGHT; r++) matrix[r] = WIDTH'($urandom);
    endtask

    // One frame of expectations; optionally change brightness or drop enable inside a row window
    task automatic run_frame(input int drop_row, input int br_row);
        int last = drop_row >= 0 ? drop_row : HEIGHT - 1;
        if (brightness != model_br) begin
            push(cfg_word(4'hA, {4'h0, brightness}), -1);
            model_br = brightness;
        end
        for (int r = 0; r <= last; r++) push(row_word(r, matrix[r]), r);
        if (br_row >= 0) begin
            wait_win(br_row);
            brightness = brightness + 4'($urandom_range(1, 15));
        end
        if (drop_row >= 0) begin
            wait_win(drop_row);
            enable = 1'b0;
            wait_idle();
        end else begin
            wait_frame_done();
        end
        randomize_matrix();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected end of run");
        $fatal(1, "watchdog");
    end

    initial begin
        int falls;
        reset = 1'b1;
        enable = 1'b0;
        brightness = 4'd7;
        randomize_matrix();
        matrix[0] = 16'h12F0;
        matrix[3] = 16'hA5C3;
        #1;
        check("reset_sck", spi_sck, 0);
        check("reset_cs_n", spi_cs_n, 1);
        check("reset_mosi", spi_mosi, 0);
        check("reset_busy", busy, 0);
        check("reset_row_select", row_select, 0);
        check("reset_frame_done", frame_done, 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("idle_busy", busy, 0);
        check("idle_cs_n", spi_cs_n, 1);
        push_init();
        enable = 1'b1;
        run_frame(-1, -1);
        run_frame(-1, 2);
        run_frame(-1, -1);
        run_frame(4, -1);
        falls = 0;
        repeat (300) begin
            @(negedge clk);
            if (!spi_cs_n) falls++;
        end
        check("no_cs_after_disable", falls, 0);
        check("busy_after_disable", busy, 0);
        check("queue_drained_after_disable", exp_q.size(), 0);
        enable = 1'b1;
        run_frame(-1, int'($urandom_range(0, HEIGHT - 1)));
        run_frame(-1, -1);
        for (int r = 0; r < HEIGHT; r++) push(row_word(r, matrix[r]), r);
        wait_win(3);
        #2 reset = 1'b1;
        #1;
        check("abort_sck", spi_sck, 0);
        check("abort_cs_n", spi_cs_n, 1);
        check("abort_mosi", spi_mosi, 0);
        check("abort_busy", busy, 0);
        check("abort_row_select", row_select, 0);
        exp_q.delete();
        brightness = 4'($urandom);
        push_init();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        run_frame(-1, -1);
        enable = 1'b0;
        repeat (20) @(negedge clk);
        check("final_busy", busy, 0);
        check("final_queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
